reg_bus_arb: RTL
================

Name: reg_bus_arb

Overview:
- Two-requester arbiter for the 6-bit-address / 8-bit-data register bus that feeds the PWM register file.
- Port 0 is the SPI instruction decoder path. Port 1 is the internal requester (status/update engine).
- Serialises accesses with round-robin fairness and drives the single read/write strobe interface into the register file.
- Returns read data to the owning requester.

Parameters:
- ADDR_W, 6, register address width
- DATA_W, 8, register data width
- LOCK_TIMEOUT, 15, idle cycles before a held lock is force-released (used only with ARB_LOCK_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  port 0 request valid
- req0_we  in  1  port 0: 1=write, 0=read
- req0_addr  in  ADDR_W  port 0 address
- req0_wdata  in  DATA_W  port 0 write data
- req0_lock  in  1  port 0 lock request (ARB_LOCK_EN only; ignored otherwise)
- req0_ready  out  1  port 0 request accepted this cycle
- req0_rvalid  out  1  port 0 read data valid (1-cycle pulse)
- req1_valid / req1_we / req1_addr / req1_wdata / req1_lock / req1_ready / req1_rvalid  same as port 0, for port 1
- rdata  out  DATA_W  read data, shared by both ports; qualify with reqN_rvalid
- read  out  1  register-file read strobe
- write  out  1  register-file write strobe
- addr  out  ADDR_W  register-file address
- data_write  out  DATA_W  register-file write data
- data_read  in  DATA_W  register-file read data, combinational, valid in the cycle read=1

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst); sampled only on the clk rising edge.
- Reset values:
  - state=IDLE, last_grant=1 (port 0 wins the first tie)
  - read, write, reqN_ready, reqN_rvalid = 0
  - addr, data_write, rdata = 0
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Arbitrates combinationally among the asserted reqN_valid.
  - Single requester: that requester wins.
  - Both requesting: the port != last_grant wins.
  - Winner sees reqN_ready=1 this cycle. On the edge: capture we/addr/wdata/port, update last_grant, go to ACCESS.
  - No request: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - read = !cur_we, write = cur_we. addr and data_write come from captured registers.
  - Read: capture data_read into rdata on the edge, go to RESP.
  - Write: go to IDLE.
- RESP (exactly 1 cycle): owner's reqN_rvalid=1, other port's rvalid=0; go to IDLE.
- Strobes and data:
  - read/write/rvalid are decoded only from registered state; never two strobes in one cycle.
  - addr and data_write hold the last granted values outside ACCESS.
  - rdata holds until the next read completes.
- Latency (accept at cycle T):
  - strobe at T+1
  - read data: rvalid at T+2
  - back-to-back throughput: write 1 per 2 cycles, read 1 per 3 cycles
- Handshake:
  - Requester holds valid and fields stable until ready.
  - Dropping valid before ready is legal: nothing is accepted.
  - ready never asserts outside IDLE.
- Addresses: full 0x00..0x3F range passed through unchecked. 16-bit registers are accessed as two independent byte transactions (LSB addr, MSB addr+1); the arbiter performs no address arithmetic.
- Reset mid-operation: at the next edge, any in-flight transaction is dropped with no strobe/rvalid afterward, state returns to IDLE, and all reset values apply.
- Request and rst in the same cycle: rst wins; the request is not accepted.

Optional Feature:
- Macro: ARB_LOCK_EN.
- With ARB_LOCK_EN, a transaction accepted with reqN_lock=1 makes that port lock owner:
  - In IDLE, only the owner can be granted; the other port waits.
  - Lock is released when an owner transaction with lock=0 is accepted.
  - Lock is also released after LOCK_TIMEOUT consecutive IDLE cycles without owner valid; a 4-bit counter, reset to 0.
  - last_grant still updates normally.
  - rst clears the lock.
- Without ARB_LOCK_EN: lock ports exist but are ignored; pure round-robin; no counter logic.

Test Plan:
1. rst=1 for 2 cycles, then 0 -> read=write=0, ready0/1=0, rvalid0/1=0, addr=0x00, rdata=0x00.
2. Port 0 write, addr=0x13, wdata=0xA6 -> req0_ready at T; write=1, addr=0x13, data_write=0xA6 at T+1 only; req1_ready stays 0.
3. Port 1 read addr=0x20 with data_read=0xCD -> read=1 at T+1; req1_rvalid=1, rdata=0xCD at T+2; req0_rvalid=0; rdata still 0xCD 5 cycles later.
4. Both ports write continuously starting right after reset (port0 addr 0x00..., port1 addr 0x3F...) -> grant order 0,1,0,1; 4 write strobes in 8 cycles; no overlapping strobes.
5. Port 0 read of 0x21 with rst=1 during its ACCESS cycle -> no req0_rvalid afterward; state IDLE; read=0 on the following cycle.
6. ARB_LOCK_EN built:
   - port 0 writes 0x10 (lock=1) then 0x11 (lock=0) while port 1 is pending -> port 0 wins both consecutively, then port 1.
   - Built without the macro -> port 1 is granted between the two port 0 writes.

Source files
------------

// File: rtl/reg_bus_arb.sv
// Two-port round-robin arbiter in front of the PWM register file bus.
// Optional lock support is compiled in with the ARB_LOCK_EN macro.
module reg_bus_arb #(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 8,
    parameter int LOCK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_lock,
    output logic              req0_ready,
    output logic              req0_rvalid,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_lock,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read,
    output logic [1:0]        o_dbg_state
);

    // Handshake: a request transfers on the rising edge where reqN_valid and
    // reqN_ready are both high; ready is only ever high in IDLE with rst low.
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t            r_state;
    logic              r_last_grant;
    logic              r_cur_we;
    logic              r_cur_port;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_read;
    logic              r_write;
    logic              r_rvalid0;
    logic              r_rvalid1;

    logic              w_block0;
    logic              w_block1;
    logic              w_req0;
    logic              w_req1;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_accept;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;

`ifdef ARB_LOCK_EN
    logic       r_lock_act;
    logic       r_lock_owner;
    logic [3:0] r_lock_cnt;
    logic       w_win_lock;
    logic       w_owner_valid;

    // While a lock is held the non-owner is masked out of arbitration.
    assign w_block0      = r_lock_act &&  r_lock_owner;
    assign w_block1      = r_lock_act && !r_lock_owner;
    assign w_win_lock    = w_grant1 ? req1_lock : req0_lock;
    assign w_owner_valid = r_lock_owner ? req1_valid : req0_valid;
`else
    logic w_unused_lock;
    assign w_unused_lock = req0_lock | req1_lock;
    assign w_block0      = 1'b0;
    assign w_block1      = 1'b0;
`endif

    assign w_req0   = req0_valid && !w_block0;
    assign w_req1   = req1_valid && !w_block1;
    assign w_grant0 = (r_state == IDLE) && !rst && w_req0 && (!w_req1 ||  r_last_grant);
    assign w_grant1 = (r_state == IDLE) && !rst && w_req1 && (!w_req0 || !r_last_grant);
    assign w_accept = w_grant0 || w_grant1;

    assign w_win_we    = w_grant1 ? req1_we    : req0_we;
    assign w_win_addr  = w_grant1 ? req1_addr  : req0_addr;
    assign w_win_wdata = w_grant1 ? req1_wdata : req0_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_cur_we     <= 1'b0;
            r_cur_port   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
`ifdef ARB_LOCK_EN
            r_lock_act   <= 1'b0;
            r_lock_owner <= 1'b0;
            r_lock_cnt   <= 4'd0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_rvalid0 <= 1'b0;
                    r_rvalid1 <= 1'b0;
                    if (w_accept) begin
                        r_cur_we     <= w_win_we;
                        r_cur_port   <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_addr       <= w_win_addr;
                        r_wdata      <= w_win_wdata;
                        r_read       <= !w_win_we;
                        r_write      <= w_win_we;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                    if (!r_cur_we) begin
                        r_rdata   <= data_read;
                        r_rvalid0 <= !r_cur_port;
                        r_rvalid1 <= r_cur_port;
                        r_state   <= RESP;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RESP: begin
                    r_rvalid0 <= 1'b0;
                    r_rvalid1 <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
`ifdef ARB_LOCK_EN
            // Every accepted transaction re-decides the lock from its lock bit.
            if (w_accept) begin
                r_lock_act   <= w_win_lock;
                r_lock_owner <= w_grant1;
                r_lock_cnt   <= 4'd0;
            end else if (r_state == IDLE && r_lock_act && !w_owner_valid) begin
                if (r_lock_cnt == 4'(LOCK_TIMEOUT - 1)) begin
                    r_lock_act <= 1'b0;
                    r_lock_cnt <= 4'd0;
                end else begin
                    r_lock_cnt <= r_lock_cnt + 4'd1;
                end
            end else begin
                r_lock_cnt <= 4'd0;
            end
`endif
        end
    end

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign req0_rvalid = r_rvalid0;
    assign req1_rvalid = r_rvalid1;
    assign rdata       = r_rdata;
    assign read        = r_read;
    assign write       = r_write;
    assign addr        = r_addr;
    assign data_write  = r_wdata;
    assign o_dbg_state = r_state;

endmodule
